// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared binary32 constants, operand layout and operand classes
package fp_mul_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int EXP_MAX = 255;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;
    typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;
endpackage

// File: rtl/fp_mul_classify.sv
// fp_mul_classify: decode one binary32 operand into class and 24-bit significand
// Subnormals classify as ZERO (denormals-are-zero).
module fp_mul_classify
    import fp_mul_pkg::*;
(
    input  logic [31:0] op_i,
    output fp_class_e   cls_o,
    output logic [23:0] sig_o
);
    fp32_t op;
    assign op    = op_i;
    assign cls_o = (op.exp == 8'hFF) ? ((op.frac != '0) ? NAN : INF) :
                   (op.exp == 8'h00) ? ZERO : NORMAL;
    assign sig_o = {1'b1, op.frac};
endmodule

// File: rtl/fp_multiplier.sv
// fp_multiplier: pipelined binary32 multiplier, RNE rounding, FTZ/DAZ, canonical NaN.
// Define FP_MUL_PIPE2_EN to register after the mantissa multiply (latency 2).
module fp_multiplier
    import fp_mul_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] mul_result
);
    fp32_t a, b;
    fp_class_e ca, cb, p_ca, p_cb;
    logic [23:0] sig_a, sig_b;
    logic [47:0] prod, p_prod;
    logic signed [9:0] esum, p_esum;
    logic sign, p_sign;
    assign a = A;
    assign b = B;
    fp_mul_classify u_cls_a (.op_i(A), .cls_o(ca), .sig_o(sig_a));
    fp_mul_classify u_cls_b (.op_i(B), .cls_o(cb), .sig_o(sig_b));
    assign sign = a.sign ^ b.sign;
    assign prod = sig_a * sig_b;
    assign esum = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - 10'sd127;
`ifdef FP_MUL_PIPE2_EN
    fp_class_e ca_q, cb_q;
    logic [47:0] prod_q;
    logic signed [9:0] esum_q;
    logic sign_q;
    always_ff @(posedge clk) begin
        if (nreset) begin
            ca_q   <= ZERO;
            cb_q   <= ZERO;
            prod_q <= '0;
            esum_q <= '0;
            sign_q <= 1'b0;
        end else begin
            ca_q   <= ca;
            cb_q   <= cb;
            prod_q <= prod;
            esum_q <= esum;
            sign_q <= sign;
        end
    end
    assign p_ca = ca_q;
    assign p_cb = cb_q;
    assign p_prod = prod_q;
    assign p_esum = esum_q;
    assign p_sign = sign_q;
`else
    assign p_ca = ca;
    assign p_cb = cb;
    assign p_prod = prod;
    assign p_esum = esum;
    assign p_sign = sign;
`endif
    // Normalise so the leading one is dropped and guard/round/sticky sit below the kept LSB
    logic [22:0] mant;
    logic g, r, s, up;
    logic [23:0] mant_r;
    logic signed [9:0] e_n, e_r;
    logic [31:0] normal_res, res_d;
    assign mant = p_prod[47] ? p_prod[46:24] : p_prod[45:23];
    assign g    = p_prod[47] ? p_prod[23] : p_prod[22];
    assign r    = p_prod[47] ? p_prod[22] : p_prod[21];
    assign s    = p_prod[47] ? |p_prod[21:0] : |p_prod[20:0];
    assign up   = g & (r | s | mant[0]);
    assign mant_r = {1'b0, mant} + {23'd0, up};
    assign e_n  = p_esum + $signed({9'd0, p_prod[47]});
    assign e_r  = e_n + $signed({9'd0, mant_r[23]});
    assign normal_res = (e_r >= 10'sd255) ? {p_sign, 8'hFF, 23'd0} :
                        (e_r <= 10'sd0)   ? {p_sign, 31'd0} :
                                            {p_sign, e_r[7:0], mant_r[22:0]};
    assign res_d = (p_ca == NAN || p_cb == NAN)                           ? QNAN :
                   ((p_ca == INF && p_cb == ZERO) || (p_ca == ZERO && p_cb == INF)) ? QNAN :
                   (p_ca == INF || p_cb == INF)                           ? {p_sign, 8'hFF, 23'd0} :
                   (p_ca == ZERO || p_cb == ZERO)                         ? {p_sign, 31'd0} :
                                                                            normal_res;
    always_ff @(posedge clk) begin
        if (nreset) mul_result <= '0;
        else        mul_result <= res_d;
    end
endmodule

// File: tb/tb_fp_multiplier.sv
// tb_fp_multiplier: directed-vector bench for fp_multiplier (latency follows FP_MUL_PIPE2_EN)
module tb_fp_multiplier;
`ifdef FP_MUL_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0;
    logic nreset = 1'b1;
    logic [31:0] A = '0, B = '0;
    logic [31:0] mul_result;
    int checks = 0, errors = 0;

    fp_multiplier dut (.clk(clk), .nreset(nreset), .A(A), .B(B), .mul_result(mul_result));

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        nreset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(32'h3FC00000, 32'h3FC00000);
            checks++;
            if (mul_result !== 32'h0) begin
                errors++;
                $display("FAIL reset[%0d] got %h want 00000000", i, mul_result);
            end
        end
        @(negedge clk);
        nreset = 1'b0;
        for (int i = 0; i < LAT; i++) drive(32'h3FC00000, 32'h3FC00000);
        checks++;
        if (mul_result !== 32'h40100000) begin
            errors++;
            $display("FAIL reset_release got %h want 40100000", mul_result);
        end
    endtask

    task automatic test_vectors(input string name, input logic [31:0] av[],
                                input logic [31:0] bv[], input logic [31:0] ev[]);
        int n;
        n = av.size();
        for (int c = 0; c < n + LAT - 1; c++) begin
            drive(c < n ? av[c] : 32'h0, c < n ? bv[c] : 32'h0);
            if (c >= LAT - 1) begin
                checks++;
                if (mul_result !== ev[c-LAT+1]) begin
                    errors++;
                    $display("FAIL %s[%0d] got %h want %h", name, c-LAT+1, mul_result, ev[c-LAT+1]);
                end
            end
        end
    endtask

    task automatic test_normals;
        logic [31:0] av[] = '{32'h3FC00000, 32'h40000000};
        logic [31:0] bv[] = '{32'h3FC00000, 32'h3FC00000};
        logic [31:0] ev[] = '{32'h40100000, 32'h40400000};
        test_vectors("normal", av, bv, ev);
    endtask

    task automatic test_back_to_back;
        logic [31:0] av[] = '{32'h414B94E2, 32'h425C7E6B, 32'h3FC00000};
        logic [31:0] bv[] = '{32'h443EF4BC, 32'h4207F35C, 32'h3FC00000};
        logic [31:0] ev[] = '{32'h4617DB1F, 32'h44EA308B, 32'h40100000};
        test_vectors("round", av, bv, ev);
    endtask

    task automatic test_sign;
        logic [31:0] av[] = '{32'hBFC00000, 32'h80000000, 32'hBFC00000};
        logic [31:0] bv[] = '{32'h3FC00000, 32'h3F800000, 32'hBFC00000};
        logic [31:0] ev[] = '{32'hC0100000, 32'h80000000, 32'h40100000};
        test_vectors("sign", av, bv, ev);
    endtask

    task automatic test_specials;
        logic [31:0] av[] = '{32'h7F800000, 32'h7FC00001, 32'hFF800000, 32'h00000000};
        logic [31:0] bv[] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'hFF800000};
        logic [31:0] ev[] = '{32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000};
        test_vectors("special", av, bv, ev);
    endtask

    task automatic test_range;
        logic [31:0] av[] = '{32'h7F000000, 32'h00800000, 32'h00000001, 32'hFF000000};
        logic [31:0] bv[] = '{32'h40000000, 32'h00800000, 32'h3F800000, 32'h40000000};
        logic [31:0] ev[] = '{32'h7F800000, 32'h00000000, 32'h00000000, 32'hFF800000};
        test_vectors("range", av, bv, ev);
    endtask

    task automatic test_reset_midstream;
        drive(32'h40000000, 32'h3FC00000);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mul_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got %h want 00000000", mul_result);
        end
        @(negedge clk);
        nreset = 1'b0;
        for (int i = 0; i < LAT; i++) drive(32'h40000000, 32'h3FC00000);
        checks++;
        if (mul_result !== 32'h40400000) begin
            errors++;
            $display("FAIL reset_mid_resume got %h want 40400000", mul_result);
        end
    endtask

    initial begin
        test_reset();
        test_normals();
        test_back_to_back();
        test_sign();
        test_specials();
        test_range();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_multiplier.md
Name: fp_multiplier

Overview:
- Single-precision (IEEE-754 binary32) floating-point multiplier with a registered output.
- Sits in the arithmetic datapath: two 32-bit operands in, one 32-bit product out.
- Fully pipelined: a new operand pair is accepted every cycle, with a fixed latency and no handshake.

Parameters:
- LATENCY_BASE, 1: cycles from operand sample to valid mul_result (informational; fixed by RTL, 2 when FP_MUL_PIPE2_EN is defined).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- nreset  input  1  reset, synchronous, active-high. Despite the name, 1 = reset asserted.
- A  input  32  operand A, binary32 (sign[31], exp[30:23], frac[22:0]).
- B  input  32  operand B, binary32.
- mul_result  output  32  registered binary32 product A*B.

Behaviour:
- Reset: while nreset=1 at a rising clk, mul_result <= 32'h00000000, and any internal pipeline registers clear to 0. Reset wins over new data. Deasserting reset mid-stream resumes normal operation on the next edge.
- Latency: A/B are sampled at rising edge N; the product is visible on mul_result after edge N (1 cycle). Throughput is 1 per cycle. mul_result holds until the next edge.
- Sign: sign = A[31] XOR B[31] for all results, including zero and inf. NaN is the exception and uses the canonical value.
- Normal path:
  - mantissas {1,fracA} x {1,fracB}: 24x24 -> 48-bit product.
  - exponent = expA + expB - 127, computed in at least 10-bit signed arithmetic.
  - If product bit 47 is set: shift right 1 and exponent+1.
- Rounding: round-to-nearest, ties-to-even, using guard, round and sticky (OR of all remaining low bits). A mantissa carry-out after rounding renormalises (exponent+1).
- Overflow: biased exponent >= 255 after rounding -> signed infinity (exp=FF, frac=0).
- Underflow: biased exponent <= 0 -> signed zero (flush-to-zero; no subnormal outputs).
- Subnormal inputs (exp=0, frac!=0) are treated as signed zero (DAZ).
- Special cases, in priority order:
  - Either operand NaN -> 32'h7FC00000 (canonical qNaN, sign 0).
  - inf x 0 -> 32'h7FC00000.
  - inf x finite nonzero, or inf x inf -> signed inf.
  - zero x finite -> signed zero.
- No exception flags.

Optional Feature:
- Macro FP_MUL_PIPE2_EN.
- Defined: an extra register stage splits the datapath after the 48-bit mantissa multiply (stage 1: classify + multiply + exponent sum; stage 2: normalise/round/pack). Latency becomes 2 cycles; throughput stays 1/cycle. Both stages clear on reset.
- Undefined: single-stage, latency 1, as above.

Decomposition:
- Package fp_mul_pkg:
  - Constants: EXP_W=8, FRAC_W=23, BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000.
  - Typedef fp32_t: packed struct {sign, exp, frac}.
  - Typedef fp_class_e: ZERO, NORMAL, INF, NAN.
- Sub-module fp_mul_classify: decodes one operand into its fp_class_e and 24-bit significand. Instantiate it twice.
- Rounding/normalisation stays in the top module.

Test Plan:
- Reset: nreset=1 for 2 edges with A=B=3FC00000 -> mul_result=00000000. Deassert; next edge -> 40100000.
- Simple normals: 3FC00000*3FC00000 -> 40100000 (1.5*1.5). 40000000*3FC00000 -> 40400000 (2.0*1.5). Checked 1 cycle after apply (2 with FP_MUL_PIPE2_EN).
- Rounding/normalise: 414B94E2*443EF4BC -> 4617DB1F; 425C7E6B*4207F35C -> 44EA308B. Back-to-back one per cycle, each result on its own cycle.
- Sign handling: BFC00000*3FC00000 -> C0100000; 80000000*3F800000 -> 80000000.
- Specials: 7F800000*00000000 -> 7FC00000; 7FC00001*3F800000 -> 7FC00000; FF800000*40000000 -> FF800000.
- Over/underflow: 7F000000*40000000 -> 7F800000; 00800000*00800000 -> 00000000; subnormal 00000001*3F800000 -> 00000000.
